// File: rtl/norm_agc_pkg.sv
// Shared types, register offsets, field positions and reset defaults for the I/Q normalizer AGC.
package norm_agc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2,
        HOLD   = 2'd3
    } agc_state_e;

    localparam int unsigned REG_CTRL     = 0;
    localparam int unsigned REG_TARGET   = 1;
    localparam int unsigned REG_WIN      = 2;
    localparam int unsigned REG_STEP     = 3;
    localparam int unsigned REG_GAIN_LIM = 4;
    localparam int unsigned REG_GAIN_INI = 5;
    localparam int unsigned REG_STATUS   = 6;
    localparam int unsigned REG_STAT     = 7;
    localparam int unsigned NUM_REGS     = 8;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_FREEZE_BIT = 1;
    localparam int unsigned CTRL_LOAD_BIT   = 2;
    localparam int unsigned FIELD_W         = 16;
    localparam int unsigned WIN_W           = 4;
    localparam int unsigned STATUS_LOCK_BIT = 16;
    localparam int unsigned STATUS_ST_LSB   = 17;

    localparam logic [15:0]      TARGET_RST   = 16'd1024;
    localparam logic [15:0]      HYST_RST     = 16'd16;
    localparam logic [WIN_W-1:0] WIN_LOG2_RST = 4'd6;
    localparam logic [15:0]      HOLD_RST     = 16'd8;
    localparam logic [15:0]      STEP_RST     = 16'd4;
    localparam logic [15:0]      GAIN_MIN_RST = 16'h0010;
    localparam logic [15:0]      GAIN_MAX_RST = 16'h1000;

    typedef struct packed {
        logic              en;
        logic              freeze;
        logic [15:0]       target;
        logic [15:0]       hyst;
        logic [WIN_W-1:0]  win_log2;
        logic [15:0]       hold;
        logic [15:0]       step;
        logic [15:0]       gain_min;
        logic [15:0]       gain_max;
        logic [15:0]       gain_init;
    } agc_cfg_t;

endpackage

// File: rtl/intbus_interf.sv
// Simple synchronous word bus: single-cycle writes, reads return rdata/rvalid one cycle later.
interface intbus_interf;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        rd;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (output addr, wdata, wr, rd, input rdata, rvalid);
    modport slave  (input addr, wdata, wr, rd, output rdata, rvalid);
endinterface

// File: rtl/norm_agc_regs.sv
// Register file for the AGC: bus decode, config storage, self-clearing load, STATUS/STAT read mux.
module norm_agc_regs
    import norm_agc_pkg::*;
#(
    parameter int unsigned       BASEADDR = 0,
    parameter int unsigned       WIDTH    = 12,
    parameter int unsigned       GWIDTH   = 16,
    parameter logic [GWIDTH-1:0] GAIN_RST = GWIDTH'(16'h0100)
) (
    input  logic              clk,
    input  logic              resetn,
    intbus_interf.slave       bus,
    input  logic [GWIDTH-1:0] gain,
    input  logic              lock,
    input  agc_state_e        state,
    input  logic [31:0]       stat_word,
    output agc_cfg_t          cfg,
    output logic              load,
    output logic              stat_rd_c
);

    logic [31:0] off_c;
    logic        hit_c;
    logic [2:0]  idx_c;
    logic [31:0] rd_mux_c;

    // Addresses below BASEADDR wrap to large offsets and miss.
    assign off_c     = bus.addr - 32'(BASEADDR);
    assign hit_c     = off_c < 32'(NUM_REGS);
    assign idx_c     = off_c[2:0];
    assign stat_rd_c = bus.rd && hit_c && (idx_c == 3'(REG_STAT));

    always_comb begin
        rd_mux_c = '0;
        case (idx_c)
            3'(REG_CTRL): begin
                rd_mux_c[CTRL_EN_BIT]     = cfg.en;
                rd_mux_c[CTRL_FREEZE_BIT] = cfg.freeze;
            end
            3'(REG_TARGET):   rd_mux_c = {cfg.hyst, cfg.target};
            3'(REG_WIN):      rd_mux_c = {cfg.hold, 12'd0, cfg.win_log2};
            3'(REG_STEP):     rd_mux_c = {16'd0, cfg.step};
            3'(REG_GAIN_LIM): rd_mux_c = {cfg.gain_max, cfg.gain_min};
            3'(REG_GAIN_INI): rd_mux_c = {16'd0, cfg.gain_init};
            3'(REG_STATUS): begin
                rd_mux_c[15:0]                              = 16'(gain);
                rd_mux_c[STATUS_LOCK_BIT]                   = lock;
                rd_mux_c[STATUS_ST_LSB+1:STATUS_ST_LSB]     = state;
            end
            default:          rd_mux_c = stat_word;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cfg.en        <= 1'b0;
            cfg.freeze    <= 1'b0;
            cfg.target    <= TARGET_RST;
            cfg.hyst      <= HYST_RST;
            cfg.win_log2  <= WIN_LOG2_RST;
            cfg.hold      <= HOLD_RST;
            cfg.step      <= STEP_RST;
            cfg.gain_min  <= GAIN_MIN_RST;
            cfg.gain_max  <= GAIN_MAX_RST;
            cfg.gain_init <= 16'(GAIN_RST);
            load          <= 1'b0;
            bus.rdata     <= '0;
            bus.rvalid    <= 1'b0;
        end else begin
            load       <= 1'b0;
            bus.rvalid <= bus.rd && hit_c;
            if (bus.rd && hit_c) begin
                bus.rdata <= rd_mux_c;
            end
            if (bus.wr && hit_c) begin
                case (idx_c)
                    3'(REG_CTRL): begin
                        cfg.en     <= bus.wdata[CTRL_EN_BIT];
                        cfg.freeze <= bus.wdata[CTRL_FREEZE_BIT];
                        load       <= bus.wdata[CTRL_LOAD_BIT];
                    end
                    3'(REG_TARGET): begin
                        cfg.target <= 16'(bus.wdata[WIDTH-1:0]);
                        cfg.hyst   <= bus.wdata[31:16];
                    end
                    3'(REG_WIN): begin
                        cfg.win_log2 <= bus.wdata[WIN_W-1:0];
                        cfg.hold     <= bus.wdata[31:16];
                    end
                    3'(REG_STEP):     cfg.step <= 16'(bus.wdata[GWIDTH-1:0]);
                    3'(REG_GAIN_LIM): begin
                        cfg.gain_min <= bus.wdata[FIELD_W-1:0];
                        cfg.gain_max <= bus.wdata[31:16];
                    end
                    3'(REG_GAIN_INI): cfg.gain_init <= 16'(bus.wdata[GWIDTH-1:0]);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/norm_agc_ctrl.sv
// Closed-loop AGC for the I/Q normalizer: windowed mean |I|+|Q| vs target, saturating gain steps with hysteresis.
// Optional peak/window statistics at offset 7 are built only when NORM_AGC_STAT_EN is defined.
module norm_agc_ctrl
    import norm_agc_pkg::*;
#(
    parameter int unsigned       BASEADDR     = 0,
    parameter int unsigned       WIDTH        = 12,
    parameter int unsigned       GWIDTH       = 16,
    parameter int unsigned       GFRAC        = 8,
    parameter int unsigned       MAX_WIN_LOG2 = 10,
    parameter logic [GWIDTH-1:0] GAIN_RST     = GWIDTH'(16'h0100)
) (
    input  logic              clk,
    input  logic              resetn,
    intbus_interf.slave       bus,
    input  logic [WIDTH-1:0]  i_in,
    input  logic [WIDTH-1:0]  q_in,
    input  logic              valid_in,
    output logic [GWIDTH-1:0] gain,
    output logic              norm_we,
    output logic              lock
);

    localparam int unsigned ACCW = WIDTH + 1 + MAX_WIN_LOG2;
    localparam int unsigned CNTW = MAX_WIN_LOG2 + 1;
    localparam int unsigned CX   = ((WIDTH > 16) ? WIDTH : 16) + 3;
    localparam int unsigned GX   = ((GWIDTH > 16) ? GWIDTH : 16) + 2;
    localparam int unsigned unused_gfrac = GFRAC;

    agc_cfg_t          cfg;
    logic              load;
    logic              stat_rd_c;
    logic [31:0]       stat_word;

    agc_state_e        state, state_nxt;
    logic [ACCW-1:0]   acc, acc_nxt;
    logic [CNTW-1:0]   cnt, cnt_nxt;
    logic [WIN_W-1:0]  win, win_nxt;
    logic [15:0]       hold_cnt, hold_cnt_nxt;
    logic [15:0]       tgt, tgt_nxt, hys, hys_nxt, stp, stp_nxt;
    logic [GWIDTH-1:0] gain_nxt;
    logic              lock_nxt;
    logic              enter_c;

    logic [WIDTH-1:0]  mag_c;
    logic [CNTW-1:0]   win_len_c;
    logic [WIN_W-1:0]  win_clamp_c;
    logic signed [CX-1:0] mean_c, hi_c, lo_c;
    logic signed [GX-1:0] g_x, dn_x, up_x, min_x, max_x;
    logic [GWIDTH-1:0] gain_dn_c, gain_up_c;

    norm_agc_regs #(
        .BASEADDR (BASEADDR),
        .WIDTH    (WIDTH),
        .GWIDTH   (GWIDTH),
        .GAIN_RST (GAIN_RST)
    ) u_regs (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .gain      (gain),
        .lock      (lock),
        .state     (state),
        .stat_word (stat_word),
        .cfg       (cfg),
        .load      (load),
        .stat_rd_c (stat_rd_c)
    );

    // Most-negative input saturates so |x| always fits in WIDTH-1 bits.
    function automatic logic [WIDTH-1:0] sat_abs(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] most_neg;
        most_neg = {1'b1, {(WIDTH-1){1'b0}}};
        if (x == most_neg) return ~most_neg;
        return x[WIDTH-1] ? -x : x;
    endfunction

    assign mag_c       = sat_abs(i_in) + sat_abs(q_in);
    assign win_len_c   = CNTW'(1) << win;
    assign win_clamp_c = (32'(cfg.win_log2) > MAX_WIN_LOG2) ? WIN_W'(MAX_WIN_LOG2) : cfg.win_log2;

    assign mean_c = CX'(acc >> win);
    assign hi_c   = CX'(tgt) + CX'(hys);
    assign lo_c   = CX'(tgt) - CX'(hys);

    assign g_x       = GX'(gain);
    assign dn_x      = g_x - GX'(stp);
    assign up_x      = g_x + GX'(stp);
    assign min_x     = GX'(cfg.gain_min);
    assign max_x     = GX'(cfg.gain_max);
    assign gain_dn_c = (dn_x < min_x) ? GWIDTH'(min_x) : GWIDTH'(dn_x);
    assign gain_up_c = (up_x > max_x) ? GWIDTH'(max_x) : GWIDTH'(up_x);

    // Next-state and gain decision; load and en override the normal window flow.
    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        cnt_nxt      = cnt;
        win_nxt      = win;
        hold_cnt_nxt = hold_cnt;
        tgt_nxt      = tgt;
        hys_nxt      = hys;
        stp_nxt      = stp;
        gain_nxt     = gain;
        lock_nxt     = lock;
        enter_c      = 1'b0;

        case (state)
            IDLE: begin
                if (cfg.en) enter_c = 1'b1;
            end
            ACCUM: begin
                if (valid_in) begin
                    acc_nxt = acc + ACCW'(mag_c);
                    cnt_nxt = cnt + CNTW'(1);
                    if (cnt == win_len_c - CNTW'(1)) state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                if (mean_c > hi_c) begin
                    lock_nxt = 1'b0;
                    if (!cfg.freeze) gain_nxt = gain_dn_c;
                end else if (mean_c < lo_c) begin
                    lock_nxt = 1'b0;
                    if (!cfg.freeze) gain_nxt = gain_up_c;
                end else begin
                    lock_nxt = 1'b1;
                end
                hold_cnt_nxt = '0;
                if (cfg.hold == 16'd0) enter_c = 1'b1;
                else                   state_nxt = HOLD;
            end
            HOLD: begin
                hold_cnt_nxt = hold_cnt + 16'd1;
                if ((17'(hold_cnt) + 17'd1) >= 17'(cfg.hold)) enter_c = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            gain_nxt  = GWIDTH'(cfg.gain_init);
            lock_nxt  = lock;
            enter_c   = cfg.en;
            state_nxt = IDLE;
        end

        // Window parameters are sampled on every ACCUM entry so mid-window writes apply next window.
        if (enter_c) begin
            state_nxt = ACCUM;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            win_nxt   = win_clamp_c;
            tgt_nxt   = cfg.target;
            hys_nxt   = cfg.hyst;
            stp_nxt   = cfg.step;
        end

        if (!cfg.en) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            win      <= WIN_LOG2_RST;
            hold_cnt <= '0;
            tgt      <= TARGET_RST;
            hys      <= HYST_RST;
            stp      <= STEP_RST;
            gain     <= GAIN_RST;
            norm_we  <= 1'b0;
            lock     <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            cnt      <= cnt_nxt;
            win      <= win_nxt;
            hold_cnt <= hold_cnt_nxt;
            tgt      <= tgt_nxt;
            hys      <= hys_nxt;
            stp      <= stp_nxt;
            gain     <= gain_nxt;
            norm_we  <= (gain_nxt != gain);
            lock     <= lock_nxt;
        end
    end

`ifdef NORM_AGC_STAT_EN
    logic [WIDTH-1:0] peak;
    logic [15:0]      win_done;

    // Peak restarts from the current sample when STAT is read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            peak     <= '0;
            win_done <= '0;
        end else begin
            if (stat_rd_c)                  peak <= valid_in ? mag_c : '0;
            else if (valid_in && mag_c > peak) peak <= mag_c;
            if (state == UPDATE) win_done <= win_done + 16'd1;
        end
    end

    assign stat_word = {win_done, 16'(peak)};
`else
    logic unused_stat_rd;
    assign unused_stat_rd = stat_rd_c;
    assign stat_word      = '0;
`endif

endmodule

// File: tb/tb_norm_agc_ctrl.sv
// Scoreboard bench for norm_agc_ctrl: expected norm_we events (cycle, gain) queued per scenario, compared against observed pulses.
module tb_norm_agc_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [11:0] i_in = '0;
    logic [11:0] q_in = '0;
    logic        valid_in = 1'b0;
    logic [15:0] gain;
    logic        norm_we;
    logic        lock;

    intbus_interf bus_if ();

    norm_agc_ctrl dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus_if),
        .i_in     (i_in),
        .q_in     (q_in),
        .valid_in (valid_in),
        .gain     (gain),
        .norm_we  (norm_we),
        .lock     (lock)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] g;
    } we_ev_t;

    we_ev_t exp_q[$];
    we_ev_t obs_q[$];
    int     cyc   = 0;
    int     tests = 0;
    int     fails = 0;

    // Records every norm_we pulse with the cycle index it appeared in.
    always @(negedge clk) begin
        if (norm_we === 1'b1) obs_q.push_back('{cyc: 32'(cyc), g: gain});
        cyc = cyc + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus_if.wr = 1'b1; bus_if.addr = a; bus_if.wdata = d;
        @(posedge clk); #1;
        bus_if.wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus_if.rd = 1'b1; bus_if.addr = a;
        @(posedge clk); #1;
        bus_if.rd = 1'b0;
        d = bus_if.rdata;
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        i_in = '0; q_in = '0; valid_in = 1'b0;
        bus_if.wr = 1'b0; bus_if.rd = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
        tick(3);
        resetn = 1'b1;
        tick(1);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic push_ev(input int c, input logic [15:0] g);
        exp_q.push_back('{cyc: 32'(c), g: g});
    endtask

    task automatic test_reset;
        logic [31:0] want [8];
        logic [31:0] d;
        do_reset();
        want = '{32'h0, 32'h0010_0400, 32'h0008_0006, 32'h4, 32'h1000_0010, 32'h100, 32'h100, 32'h0};
        tests++; if (gain !== 16'h0100) begin fails++; $display("FAIL reset_gain: got %h want 0100", gain); end
        tests++; if (norm_we !== 1'b0)  begin fails++; $display("FAIL reset_we: got %b want 0", norm_we); end
        tests++; if (lock !== 1'b0)     begin fails++; $display("FAIL reset_lock: got %b want 0", lock); end
        for (int a = 0; a < 8; a++) begin
            bus_read(32'(a), d);
            tests++;
            if (d !== want[a]) begin fails++; $display("FAIL reset_reg%0d: got %h want %h", a, d, want[a]); end
        end
    endtask

    task automatic test_step_up;
        int base; we_ev_t e, o;
        do_reset();
        i_in = 12'd256; q_in = 12'd256; valid_in = 1'b1;
        bus_write(32'd0, 32'h1);
        base = cyc;
        push_ev(base + 66, 16'h0104);
        push_ev(base + 139, 16'h0108);
        tick(145);
        tests++; if (lock !== 1'b0) begin fails++; $display("FAIL up_lock: got %b want 0", lock); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL up_we: no pulse, want %h at +%0d", e.g, e.cyc - 32'(base)); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL up_we: got %h at +%0d want %h at +%0d", o.g, o.cyc - 32'(base), e.g, e.cyc - 32'(base)); end
            end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL up_extra: got %0d extra pulses want 0", obs_q.size()); end
    endtask

    task automatic test_step_down;
        int base; we_ev_t e, o;
        do_reset();
        i_in = 12'd600; q_in = 12'd600; valid_in = 1'b1;
        bus_write(32'd0, 32'h1);
        base = cyc;
        push_ev(base + 66, 16'h00FC);
        tick(100);
        tests++; if (lock !== 1'b0)     begin fails++; $display("FAIL dn_lock: got %b want 0", lock); end
        tests++; if (gain !== 16'h00FC) begin fails++; $display("FAIL dn_gain: got %h want 00fc", gain); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL dn_we: no pulse, want %h at +%0d", e.g, e.cyc - 32'(base)); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL dn_we: got %h at +%0d want %h at +%0d", o.g, o.cyc - 32'(base), e.g, e.cyc - 32'(base)); end
            end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL dn_extra: got %0d extra pulses want 0", obs_q.size()); end
    endtask

    task automatic test_lock;
        logic [31:0] d;
        do_reset();
        i_in = 12'd510; q_in = 12'd510; valid_in = 1'b1;
        bus_write(32'd0, 32'h1);
        tick(100);
        tests++; if (lock !== 1'b1)     begin fails++; $display("FAIL lock_lock: got %b want 1", lock); end
        tests++; if (gain !== 16'h0100) begin fails++; $display("FAIL lock_gain: got %h want 0100", gain); end
        bus_read(32'd6, d);
        tests++; if (d !== 32'h0003_0100) begin fails++; $display("FAIL lock_status: got %h want 00030100", d); end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL lock_we: got %0d pulses want 0", obs_q.size()); end
    endtask

    task automatic test_sat_max;
        int base; we_ev_t e, o;
        do_reset();
        bus_write(32'd4, 32'h0108_0010);
        i_in = 12'd64; q_in = 12'd64; valid_in = 1'b1;
        bus_write(32'd0, 32'h1);
        base = cyc;
        push_ev(base + 66, 16'h0104);
        push_ev(base + 139, 16'h0108);
        tick(290);
        tests++; if (gain !== 16'h0108) begin fails++; $display("FAIL max_gain: got %h want 0108", gain); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL max_we: no pulse, want %h at +%0d", e.g, e.cyc - 32'(base)); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL max_we: got %h at +%0d want %h at +%0d", o.g, o.cyc - 32'(base), e.g, e.cyc - 32'(base)); end
            end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL max_extra: got %0d extra pulses want 0", obs_q.size()); end
    endtask

    task automatic test_neg_full;
        int base; we_ev_t e, o;
        do_reset();
        bus_write(32'd2, 32'h0008_000F);
        i_in = 12'h800; q_in = 12'h800; valid_in = 1'b1;
        bus_write(32'd0, 32'h1);
        base = cyc;
        push_ev(base + 2 + 1024, 16'h00FC);
        tick(1035);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL neg_we: no pulse, want %h at +%0d", e.g, e.cyc - 32'(base)); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL neg_we: got %h at +%0d want %h at +%0d", o.g, o.cyc - 32'(base), e.g, e.cyc - 32'(base)); end
            end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL neg_extra: got %0d extra pulses want 0", obs_q.size()); end
    endtask

    task automatic test_en_drop;
        int base; we_ev_t e, o; logic [31:0] d;
        do_reset();
        i_in = 12'd256; q_in = 12'd256; valid_in = 1'b1;
        bus_write(32'd0, 32'h1);
        tick(30);
        bus_write(32'd0, 32'h0);
        tick(80);
        bus_read(32'd6, d);
        tests++; if (d !== 32'h0000_0100) begin fails++; $display("FAIL drop_status: got %h want 00000100", d); end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL drop_we: got %0d pulses want 0", obs_q.size()); end
        obs_q.delete();
        bus_write(32'd0, 32'h1);
        base = cyc;
        push_ev(base + 66, 16'h0104);
        tick(70);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL reen_we: no pulse, want %h at +%0d", e.g, e.cyc - 32'(base)); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL reen_we: got %h at +%0d want %h at +%0d", o.g, o.cyc - 32'(base), e.g, e.cyc - 32'(base)); end
            end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL reen_extra: got %0d extra pulses want 0", obs_q.size()); end
    endtask

    task automatic test_load;
        int base; we_ev_t e, o;
        do_reset();
        bus_write(32'd5, 32'h0000_0200);
        i_in = 12'd256; q_in = 12'd256; valid_in = 1'b1;
        bus_write(32'd0, 32'h5);
        base = cyc;
        push_ev(base + 1, 16'h0200);
        push_ev(base + 66, 16'h0204);
        tick(1);
        tests++; if (gain !== 16'h0200 || norm_we !== 1'b1) begin fails++; $display("FAIL load_now: got %h/%b want 0200/1", gain, norm_we); end
        tick(69);
        // Reload mid-HOLD changes the gain and restarts the window.
        bus_write(32'd0, 32'h5);
        base = cyc;
        push_ev(base + 1, 16'h0200);
        tick(5);
        // Reload with an unchanged value: no pulse, window restarts again.
        bus_write(32'd0, 32'h5);
        base = cyc;
        push_ev(base + 66, 16'h0204);
        tick(70);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL load_we: no pulse, want %h at %0d", e.g, e.cyc); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL load_we: got %h at %0d want %h at %0d", o.g, o.cyc, e.g, e.cyc); end
            end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL load_extra: got %0d extra pulses want 0", obs_q.size()); end
    endtask

    task automatic test_freeze;
        do_reset();
        i_in = 12'd600; q_in = 12'd600; valid_in = 1'b1;
        bus_write(32'd0, 32'h3);
        tick(150);
        tests++; if (gain !== 16'h0100) begin fails++; $display("FAIL frz_gain: got %h want 0100", gain); end
        tests++; if (lock !== 1'b0)     begin fails++; $display("FAIL frz_lock: got %b want 0", lock); end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL frz_we: got %0d pulses want 0", obs_q.size()); end
    endtask

    task automatic test_async_reset;
        do_reset();
        i_in = 12'd256; q_in = 12'd256; valid_in = 1'b1;
        bus_write(32'd0, 32'h1);
        tick(70);
        tests++; if (gain !== 16'h0104) begin fails++; $display("FAIL ar_pre: got %h want 0104", gain); end
        #3;
        resetn = 1'b0;
        #1;
        tests++; if (gain !== 16'h0100 || norm_we !== 1'b0 || lock !== 1'b0) begin
            fails++; $display("FAIL ar_now: got %h/%b/%b want 0100/0/0", gain, norm_we, lock);
        end
        tick(2);
        tests++; if (norm_we !== 1'b0) begin fails++; $display("FAIL ar_we: got %b want 0", norm_we); end
        resetn = 1'b1;
    endtask

    initial begin
        bus_if.wr = 1'b0; bus_if.rd = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
        test_reset();
        test_step_up();
        test_step_down();
        test_lock();
        test_sat_max();
        test_neg_full();
        test_en_drop();
        test_load();
        test_freeze();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
